// File: rtl/cc_mux_n1_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cc_mux_n1_arb
//  Purpose  : N:1 data multiplexer with a registered valid/ready output stage.
//             The channel is picked either by an explicit select index
//             (mode 0) or by a round-robin arbiter (mode 1).
//  Revision : 1.0  initial release
// ============================================================================
module cc_mux_n1_arb #(
  parameter int NUMBER_DATAWIDTH   = 8,
  parameter int NUMBER_CHANNELS    = 4,
  parameter int NUMBER_SELECTWIDTH = 2
) (
  input  logic                                        CC_MUX_N1_ARB_CLOCK_50,
  input  logic                                        CC_MUX_N1_ARB_RESET_InLow,
  input  logic                                        CC_MUX_N1_ARB_mode_In,
  input  logic [NUMBER_SELECTWIDTH-1:0]               CC_MUX_N1_ARB_select_InBUS,
  input  logic [NUMBER_DATAWIDTH*NUMBER_CHANNELS-1:0] CC_MUX_N1_ARB_data_InBUS,
  input  logic [NUMBER_CHANNELS-1:0]                  CC_MUX_N1_ARB_valid_InBUS,
  output logic [NUMBER_CHANNELS-1:0]                  CC_MUX_N1_ARB_ready_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0]                 CC_MUX_N1_ARB_z_Out,
  output logic                                        CC_MUX_N1_ARB_valid_Out,
  output logic [NUMBER_SELECTWIDTH-1:0]               CC_MUX_N1_ARB_channel_Out,
  input  logic                                        CC_MUX_N1_ARB_ready_In
);

  localparam int W  = NUMBER_DATAWIDTH;
  localparam int N  = NUMBER_CHANNELS;
  localparam int SW = NUMBER_SELECTWIDTH;

  // Refuse to elaborate with an unusable channel count or a select bus too
  // narrow to address every channel.
  generate
    if (N < 2) begin : g_chk_channels
      $error("cc_mux_n1_arb: NUMBER_CHANNELS must be at least 2");
    end
    if ((1 << SW) < N) begin : g_chk_selectwidth
      $error("cc_mux_n1_arb: 2**NUMBER_SELECTWIDTH must cover NUMBER_CHANNELS");
    end
  endgenerate

  logic [W-1:0]  z_q, z_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] channel_q, channel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          xfer;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;

  // Grant selection: explicit index in mode 0, rotating priority from ptr in mode 1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!CC_MUX_N1_ARB_mode_In) begin
      // Out-of-range selects never match any channel, so nothing is granted.
      for (int i = 0; i < N; i++) begin
        if (CC_MUX_N1_ARB_select_InBUS == SW'(i) && CC_MUX_N1_ARB_valid_InBUS[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      // First pass: lowest valid channel overall (the wrapped part of the scan).
      for (int i = N - 1; i >= 0; i--) begin
        if (CC_MUX_N1_ARB_valid_InBUS[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
      // Second pass: a valid channel at or above ptr takes precedence.
      for (int i = N - 1; i >= 0; i--) begin
        if (CC_MUX_N1_ARB_valid_InBUS[i] && (SW'(i) >= ptr_q)) begin
          grant_idx = SW'(i);
        end
      end
    end
  end

  // Handshake and data steering for the granted channel.
  always_comb begin
    load       = !valid_q || CC_MUX_N1_ARB_ready_In;
    xfer       = load && grant_vld;
    grant_data = '0;
    CC_MUX_N1_ARB_ready_OutBUS = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = CC_MUX_N1_ARB_data_InBUS[i*W +: W];
        // Reset gating keeps every channel stalled while reset is held.
        CC_MUX_N1_ARB_ready_OutBUS[i] = xfer && CC_MUX_N1_ARB_RESET_InLow;
      end
    end
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    z_d       = z_q;
    valid_d   = valid_q;
    channel_d = channel_q;
    ptr_d     = ptr_q;
    if (load) begin
      if (grant_vld) begin
        z_d       = grant_data;
        channel_d = grant_idx;
        valid_d   = 1'b1;
      end else begin
        valid_d   = 1'b0;
      end
    end
    if (xfer && CC_MUX_N1_ARB_mode_In) begin
      ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CC_MUX_N1_ARB_CLOCK_50 or negedge CC_MUX_N1_ARB_RESET_InLow) begin
    if (!CC_MUX_N1_ARB_RESET_InLow) begin
      z_q       <= '0;
      valid_q   <= 1'b0;
      channel_q <= '0;
      ptr_q     <= '0;
    end else begin
      z_q       <= z_d;
      valid_q   <= valid_d;
      channel_q <= channel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign CC_MUX_N1_ARB_z_Out       = z_q;
  assign CC_MUX_N1_ARB_valid_Out   = valid_q;
  assign CC_MUX_N1_ARB_channel_Out = channel_q;

endmodule
`default_nettype wire

// File: doc/cc_mux_n1_arb.md
Name: cc_mux_n1_arb

Overview:
- Parametrised N:1 multiplexer. Successor to the combinational 2:1 data mux.
- Adds a registered output stage with a valid/ready handshake.
- Two selection modes, chosen at run time: explicit select, or round-robin arbitration.
- Sits between several producer channels and a single consumer, such as a shared datapath or display bus.

Parameters:
- NUMBER_DATAWIDTH, 8: bits per data channel.
- NUMBER_CHANNELS, 4: number of input channels N, with N ≥ 2.
- NUMBER_SELECTWIDTH, 2: width of select and channel index. 2^NUMBER_SELECTWIDTH ≥ NUMBER_CHANNELS is required; violating it is an elaboration error.

Ports:
- CC_MUX_N1_ARB_CLOCK_50  in  1  system clock; all state updates on the rising edge.
- CC_MUX_N1_ARB_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_MUX_N1_ARB_mode_In  in  1  selection mode: 0 = explicit select, 1 = round-robin.
- CC_MUX_N1_ARB_select_InBUS  in  NUMBER_SELECTWIDTH  channel index used when mode = 0.
- CC_MUX_N1_ARB_data_InBUS  in  NUMBER_DATAWIDTH*NUMBER_CHANNELS  flattened channel data; channel i occupies [i*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH].
- CC_MUX_N1_ARB_valid_InBUS  in  NUMBER_CHANNELS  per-channel valid.
- CC_MUX_N1_ARB_ready_OutBUS  out  NUMBER_CHANNELS  per-channel accept (combinational).
- CC_MUX_N1_ARB_z_Out  out  NUMBER_DATAWIDTH  registered output data.
- CC_MUX_N1_ARB_valid_Out  out  1  output data valid.
- CC_MUX_N1_ARB_channel_Out  out  NUMBER_SELECTWIDTH  index of the channel that produced z_Out.
- CC_MUX_N1_ARB_ready_In  in  1  downstream ready.

Behaviour:
- Reset: asserting RESET_InLow low clears state immediately, independent of clock. z_Out = 0, valid_Out = 0, channel_Out = 0, round-robin pointer = 0. Reset mid-transfer discards any held word; ready_OutBUS = 0 while in reset.
- Load condition: load = !valid_Out || ready_In. The output register accepts a new word only when load = 1.
- Grant, mode 0: grant channel select_InBUS only if select_InBUS < N and valid_InBUS[select] = 1.
  - select ≥ N: never grant; the output drains and stays empty.
- Grant, mode 1: scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1 and grant the first with valid = 1. No valid channel means no grant.
- Handshake: ready_OutBUS[i] = load && granted && (grant index == i). At most one bit is set. A transfer on channel i occurs when valid_InBUS[i] && ready_OutBUS[i].
- On transfer:
  - z_Out <= channel data.
  - channel_Out <= grant index.
  - valid_Out <= 1.
- When load = 1 and no grant: valid_Out <= 0 on the next edge. z_Out and channel_Out keep their last value.
- Stall: valid_Out = 1 and ready_In = 0 holds z_Out, channel_Out and valid_Out stable. All ready_OutBUS = 0.
- Latency: 1 cycle from input transfer to valid_Out.
- Throughput: 1 word/cycle while ready_In = 1.
- Round-robin pointer:
  - Updates only on a mode-1 transfer: ptr <= (grant + 1) mod N, wrapping N-1 → 0.
  - Unchanged in mode 0 and on cycles with no transfer.
- Mode and select are sampled combinationally each cycle. A change applies to the same cycle's grant; an already-registered word is unaffected.
- Simultaneous consume and load: an output word consumed (ready_In = 1) in the same cycle a new transfer occurs is replaced without a bubble.
- Mode 1 starvation bound: a continuously-valid channel is granted within N transfers.

Test Plan:
- Reset/idle: hold RESET_InLow = 0 for 3 cycles with all valids = 1 → z_Out = 0, valid_Out = 0, channel_Out = 0, ready_OutBUS = 0. Assert reset asynchronously mid-stream → outputs clear before the next edge.
- Mode 0 steer: N = 4, W = 8, data = {0x44,0x33,0x22,0x11}, all valid, ready_In = 1, select stepping 0..3 → z_Out = 0x11,0x22,0x33,0x44 one cycle later each. channel_Out matches select; only ready_OutBUS[select] = 1.
- Mode 0 out-of-range: N = 3, SELECTWIDTH = 2, select = 3 → no ready_OutBUS bit set; valid_Out falls to 0 after one cycle.
- Round-robin fairness: mode 1, all valid, ready_In = 1 for 8 cycles → channel_Out sequence 0,1,2,3,0,1,2,3. With only channels 1 and 3 valid → 1,3,1,3.
- Backpressure: mode 1, ready_In = 0 for 4 cycles after the first word (0x11 on ch0) → z_Out = 0x11, valid_Out = 1, channel_Out = 0 held. ready_OutBUS = 0 and ptr frozen at 1. On ready_In = 1 the next grant is ch1 (0x22).
- Wrap and mode switch: mode 1, last grant ch3 → ptr wraps to 0. Switch to mode 0 with select = 2 for 2 transfers, then back to mode 1 → next grant is ch0 (ptr unchanged by the mode-0 transfers).
